// File: rtl/dmem_write_buffer.sv
// Posted-store buffer in front of the data memory port.
// Stores queue in a circular FIFO and drain on idle cycles; loads forward from the youngest match.
module dmem_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_we,
    input  logic                     cpu_re,
    input  logic [31:0]              cpu_a,
    input  logic [31:0]              cpu_wd,
    output logic [31:0]              cpu_rd,
    output logic                     stall,
    output logic                     mem_we,
    output logic [31:0]              mem_a,
    output logic [31:0]              mem_wd,
    input  logic [31:0]              mem_rd,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [29:0]   tag_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    logic        full, load, drain, push;
    logic [31:0] fwd_data;
    logic [PW-1:0] idx;
    logic        unused_low_bits;

    assign unused_low_bits = ^cpu_a[1:0];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign load  = cpu_re & ~cpu_we;
    assign drain = ~empty & ~load & (~cpu_we | full);
    assign push  = cpu_we & ~full;
    assign stall = cpu_we & full;

    always_comb begin
        mem_we = 1'b0;
        mem_a  = {cpu_a[31:2], 2'b00};
        mem_wd = cpu_wd;
        if (drain) begin
            mem_we = 1'b1;
            mem_a  = {tag_q[head_q], 2'b00};
            mem_wd = data_q[head_q];
        end
    end

    // Walk oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        fwd_data = mem_rd;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (tag_q[idx] == cpu_a[31:2])) begin
                fwd_data = data_q[idx];
            end
        end
    end

    assign cpu_rd = load ? fwd_data : mem_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (drain) begin
                head_q <= head_q + PW'(1);
            end
            // push and drain are mutually exclusive: drain with cpu_we requires full
            if (push && !drain) begin
                count_q <= count_q + CW'(1);
            end else if (drain && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Entry contents are not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail_q]  <= cpu_a[31:2];
            data_q[tail_q] <= cpu_wd;
        end
    end

endmodule
